// File: rtl/start_token_fifo_srl_if.sv
// ---------------------------------------------------------------------------
// start_token_fifo_srl_if
//
// Handshake bundle between a start-token FIFO and its neighbours.
// Producer side: if_write / if_write_ce / if_din, back-pressured by if_full_n.
// Consumer side: if_read / if_read_ce, fed by if_empty_n / if_dout (show-ahead)
// plus the registered occupancy if_num_data_valid.
//
// Modports:
//   slave  - the FIFO itself (drives flags, head word and occupancy)
//   master - the surrounding logic (drives requests, enables and write data)
// ---------------------------------------------------------------------------
interface start_token_fifo_srl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);

  // Producer side
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;

  // Consumer side
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   if_num_data_valid;

  modport slave (
    output if_full_n,
    input  if_write_ce,
    input  if_write,
    input  if_din,
    output if_empty_n,
    input  if_read_ce,
    input  if_read,
    output if_dout,
    output if_num_data_valid
  );

  modport master (
    input  if_full_n,
    output if_write_ce,
    output if_write,
    output if_din,
    input  if_empty_n,
    output if_read_ce,
    output if_read,
    input  if_dout,
    input  if_num_data_valid
  );

endinterface : start_token_fifo_srl_if

// File: rtl/start_token_fifo_srl.sv
// ---------------------------------------------------------------------------
// start_token_fifo_srl
//
// Show-ahead FIFO built on an SRL-style shift register. Every accepted write
// shifts the whole array by one entry and inserts the new word at entry 0, so
// the oldest word sits at entry (count-1). A registered read address tracks
// that entry and drives the head word combinationally onto if_dout.
//
// Ports:
//   ap_clk   - single clock, all state changes on the rising edge
//   ap_rst_n - synchronous active-low reset
//   fifo     - start_token_fifo_srl_if.slave handshake bundle
//                if_full_n / if_empty_n / if_num_data_valid are registered,
//                so no combinational path exists from the requests to them.
//
// Parameters:
//   DATA_WIDTH - width of each stored word
//   ADDR_WIDTH - read-address width, 2**ADDR_WIDTH must be >= DEPTH
//   DEPTH      - number of entries, at least 2
// ---------------------------------------------------------------------------
module start_token_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  start_token_fifo_srl_if.slave         fifo
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  // Elaboration-time guard on the parameter contract.
  if (DEPTH < 2 || (2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_params
    $error("start_token_fifo_srl: need DEPTH >= 2 and 2**ADDR_WIDTH >= DEPTH");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  full_n;
  logic                  empty_n;

  logic push;
  logic pop;

  // Requests are qualified by the registered flags, so a write while full or a
  // read while empty is silently dropped.
  assign push = fifo.if_write & fifo.if_write_ce & full_n;
  assign pop  = fifo.if_read  & fifo.if_read_ce  & empty_n;

  // -------------------------------------------------------------------------
  // Storage: plain shift register with a single enable (push).
  // -------------------------------------------------------------------------
  // NOTE: the storage array carries no reset on purpose; adding one would stop
  // it mapping onto shift-register primitives. Its contents are only observed
  // through if_dout, which is don't-care while the FIFO is empty.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem[0] <= fifo.if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy and read-address update
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    addr_next  = addr;
    unique case ({push, pop})
      2'b10: begin
        count_next = count + 1'b1;
        // Before the shift the oldest word was at count-1; after it, at count.
        // A push into an empty FIFO lands at entry 0, where addr already is.
        if (count != '0) begin
          addr_next = count[ADDR_WIDTH-1:0];
        end
      end
      2'b01: begin
        count_next = count - 1'b1;
        // The head moves one entry towards 0; the last remaining word pops
        // back to an empty FIFO with addr parked at 0.
        if (count_next != '0) begin
          addr_next = addr - 1'b1;
        end
      end
      // Push and pop together: the shift moves the next-oldest word into the
      // slot addr already points at, so both count and addr hold.
      default: begin
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count   <= '0;
      addr    <= '0;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
    end else begin
      count   <= count_next;
      addr    <= addr_next;
      full_n  <= (count_next != DEPTH_CNT);
      empty_n <= (count_next != '0);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign fifo.if_full_n         = full_n;
  assign fifo.if_empty_n        = empty_n;
  assign fifo.if_num_data_valid = count;
  assign fifo.if_dout           = mem[addr];

endmodule : start_token_fifo_srl

// File: tb/tb_start_token_fifo_srl.sv
// ---------------------------------------------------------------------------
// tb_start_token_fifo_srl
//
// Two FIFOs (DEPTH=2 and DEPTH=4, 8-bit data) share one stimulus stream.
// Each is compared every cycle against a list model: an array holding the
// queued words oldest-first plus an element count.
// ---------------------------------------------------------------------------
module tb_start_token_fifo_srl;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic          rst_n = 1'b0;
  logic          wr    = 1'b0;
  logic          wce   = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          rd    = 1'b0;
  logic          rce   = 1'b0;

  start_token_fifo_srl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(1)) ifa ();
  start_token_fifo_srl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) ifb ();

  assign ifa.if_write    = wr;
  assign ifa.if_write_ce = wce;
  assign ifa.if_din      = din;
  assign ifa.if_read     = rd;
  assign ifa.if_read_ce  = rce;
  assign ifb.if_write    = wr;
  assign ifb.if_write_ce = wce;
  assign ifb.if_din      = din;
  assign ifb.if_read     = rd;
  assign ifb.if_read_ce  = rce;

  start_token_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(2)) dut_a (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .fifo     (ifa.slave)
  );

  start_token_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .DEPTH(4)) dut_b (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .fifo     (ifb.slave)
  );

  // Reference model: words oldest-first, index 0 is the head.
  logic [DW-1:0] mdata [2][4];
  int            mcnt  [2];
  int            mdepth[2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge to model k using the stimulus present at that edge.
  task automatic model_edge(input int k);
    bit do_push, do_pop;
    if (!rst_n) begin
      mcnt[k] = 0;
      return;
    end
    do_push = wr && wce && (mcnt[k] < mdepth[k]);
    do_pop  = rd && rce && (mcnt[k] > 0);
    if (do_pop) begin
      for (int i = 0; i < 3; i++) mdata[k][i] = mdata[k][i+1];
      mcnt[k]--;
    end
    if (do_push) begin
      mdata[k][mcnt[k]] = din;
      mcnt[k]++;
    end
  endtask

  task automatic check_duts();
    check("a.empty_n", 32'(ifa.if_empty_n),        32'(mcnt[0] != 0));
    check("a.full_n",  32'(ifa.if_full_n),         32'(mcnt[0] != mdepth[0]));
    check("a.count",   32'(ifa.if_num_data_valid), 32'(mcnt[0]));
    if (mcnt[0] != 0) check("a.dout", 32'(ifa.if_dout), 32'(mdata[0][0]));
    check("b.empty_n", 32'(ifb.if_empty_n),        32'(mcnt[1] != 0));
    check("b.full_n",  32'(ifb.if_full_n),         32'(mcnt[1] != mdepth[1]));
    check("b.count",   32'(ifb.if_num_data_valid), 32'(mcnt[1]));
    if (mcnt[1] != 0) check("b.dout", 32'(ifb.if_dout), 32'(mdata[1][0]));
  endtask

  // One clock: stimulus already set; update the models at the edge and
  // compare #1 later, then the caller may change stimulus.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_duts();
  endtask

  task automatic set_in(input logic w, input logic wc, input logic [DW-1:0] d,
                        input logic r, input logic rc);
    wr = w; wce = wc; din = d; rd = r; rce = rc;
  endtask

  initial begin
    mdepth[0] = 2;
    mdepth[1] = 4;
    mcnt[0]   = 0;
    mcnt[1]   = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) mdata[k][i] = '0;

    // Reset, then idle for 5 cycles with no requests.
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("reset.a_full_n",  32'(ifa.if_full_n),  32'd1);
    check("reset.a_empty_n", 32'(ifa.if_empty_n), 32'd0);

    // Fill and overflow: 0x11, 0x22, 0x33 back-to-back.
    set_in(1'b1, 1'b1, 8'h11, 1'b0, 1'b0); step();
    set_in(1'b1, 1'b1, 8'h22, 1'b0, 1'b0); step();
    check("fill.a_full_n", 32'(ifa.if_full_n), 32'd0);
    set_in(1'b1, 1'b1, 8'h33, 1'b0, 1'b0); step();
    check("ovf.a_count", 32'(ifa.if_num_data_valid), 32'd2);
    check("ovf.a_dout",  32'(ifa.if_dout),           32'h11);
    check("ovf.b_count", 32'(ifb.if_num_data_valid), 32'd3);

    // Drain with three consecutive pops.
    set_in(1'b0, 1'b1, 8'h00, 1'b1, 1'b1); step();
    check("drain.a_dout", 32'(ifa.if_dout), 32'h22);
    step();
    check("drain.a_empty_n", 32'(ifa.if_empty_n), 32'd0);
    step();
    check("drain.a_count", 32'(ifa.if_num_data_valid), 32'd0);

    // Simultaneous push/pop at count=1.
    set_in(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1); step();
    check("sim.a_head", 32'(ifa.if_dout), 32'hA5);
    set_in(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1); step();
    check("sim.a_count",   32'(ifa.if_num_data_valid), 32'd1);
    check("sim.a_dout",    32'(ifa.if_dout),           32'h5A);
    check("sim.a_full_n",  32'(ifa.if_full_n),         32'd1);
    check("sim.a_empty_n", 32'(ifa.if_empty_n),        32'd1);

    // Enable gating: requests held high with both enables low.
    set_in(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("ce.a_count", 32'(ifa.if_num_data_valid), 32'd1);
    check("ce.a_dout",  32'(ifa.if_dout),           32'h5A);

    // Bring DEPTH=4 FIFO to 3 words, then reset for one cycle.
    set_in(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0); step();
    set_in(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0); step();
    check("pre_rst.b_count", 32'(ifb.if_num_data_valid), 32'd3);
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1); step();
    rst_n = 1'b1;
    check("rst.b_count",   32'(ifb.if_num_data_valid), 32'd0);
    check("rst.b_empty_n", 32'(ifb.if_empty_n),        32'd0);
    check("rst.b_full_n",  32'(ifb.if_full_n),         32'd1);
    set_in(1'b1, 1'b1, 8'h77, 1'b0, 1'b0); step();
    check("rst.b_dout", 32'(ifb.if_dout), 32'h77);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
             8'($urandom()),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_start_token_fifo_srl

// File: doc/start_token_fifo_srl.md
Name: start_token_fifo_srl

Overview:
- Handshake FIFO controller that owns an SRL-style shift-register storage array (DEPTH × DATA_WIDTH).
- Carries start tokens and small data words between neighbouring dataflow processes in the i4xi4 linear-layer array, e.g. from the dispatcher into each PE_i4xi4_pack instance.
- Producer side uses the if_write/if_full_n handshake; consumer side uses if_read/if_empty_n, and the head word is presented show-ahead on if_dout.
- Occupancy counting, flag generation and the read address into the shift array are all handled here.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- ADDR_WIDTH, 1, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 2, number of storage entries; legal range is ≥ 2.

Ports:
- ap_clk  in  1  single clock; all state updates on the rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- if_full_n  out  1  high when at least one free entry exists.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  high when at least one valid entry exists.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  head-of-queue word, show-ahead.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, registered.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge):
  - count=0, addr=0, if_full_n=1, if_empty_n=0, if_num_data_valid=0.
  - Storage contents are not reset; if_dout is don't-care while if_empty_n=0.
  - Reset mid-operation discards all queued words; flags take reset values at that same edge; inputs are ignored while in reset.
- Push: push = if_write & if_write_ce & if_full_n.
  - On push, storage shifts (entry i → i+1) and if_din enters entry 0, like an SRL16/32 primitive.
  - A write request while if_full_n=0 is ignored: no shift, no state change.
- Pop: pop = if_read & if_read_ce & if_empty_n.
  - A read request while if_empty_n=0 is ignored.
- Occupancy and read address (all registered):
  - push only: count+1; addr = count (old value), except when old count=0, where addr stays 0.
  - pop only: count−1; addr−1, except when new count=0, where addr stays 0.
  - push & pop together: count and addr unchanged; storage still shifts, so addr now points at the next-oldest word.
  - neither: hold.
- if_dout = storage[addr], combinational from registered addr. The oldest word is always at the head; strict FIFO order.
- Flags, registered from count_next:
  - if_full_n = (count_next != DEPTH).
  - if_empty_n = (count_next != 0).
  - if_num_data_valid = count_next.
- Latency:
  - A word pushed into an empty FIFO appears on if_dout with if_empty_n=1 one cycle after the push edge.
  - A pop frees space, and if_full_n rises one cycle after the pop edge.
- Boundaries:
  - Simultaneous push & pop when full is impossible, since push is gated by if_full_n; pop proceeds and count becomes DEPTH−1.
  - Simultaneous push & pop when empty: pop is gated, so push only.
  - No combinational path from if_read/if_write to if_full_n/if_empty_n.
- Implementation:
  - Storage is inferred as a shift-register array with no reset, so it maps to SRL.
  - Controller and storage live in this module; no submodules are required.

Test Plan:
- Reset release, DEPTH=2, DATA_WIDTH=8: no requests → if_full_n=1, if_empty_n=0, if_num_data_valid=0 for 5 cycles.
- Fill and overflow: push 0x11, 0x22, then 0x33 on the next cycle → if_full_n=0 after second push, 0x33 discarded, count=2, if_dout=0x11.
- Drain in order: pop three cycles running → if_dout shows 0x11 then 0x22, if_empty_n=0 after second pop, third pop ignored, count stays 0.
- Simultaneous push/pop at count=1 (head 0xA5), push 0x5A with pop → count stays 1, next-cycle if_dout=0x5A, flags unchanged.
- CE gating: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 → no state change over 4 cycles.
- Reset mid-stream with DEPTH=4 holding 3 words: assert ap_rst_n=0 for 1 cycle → count=0, if_empty_n=0, if_full_n=1; next push 0x77 reads back as 0x77.
